uart_text_console: RTL and testbench

//  Character-terminal front end for the LCD text VRAM. Takes a byte stream (UART RX
//  or MCU) via valid/ready and turns it into VRAM write strobes. Adds a cursor,

---
 rtl/uart_text_console_pkg.sv | 46 ++++
 rtl/uart_text_console_cursor.sv | 68 ++++++
 rtl/uart_text_console.sv | 128 ++++++++++++
 tb/tb_uart_text_console.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_text_console_pkg.sv
// Shared definitions for the text console: ASCII control codes, FSM states,
// cursor operations and the byte-to-operation decoder.
package uart_text_console_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_FF  = 8'h0C;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_WRITE,
        S_CLEAR_LINE,
        S_CLEAR_ALL
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADVANCE,
        OP_CR,
        OP_LF,
        OP_BS,
        OP_TAB,
        OP_HOME
    } cursor_op_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic cursor_op_t decode_op(input logic [7:0] c);
        if (is_printable(c)) return OP_ADVANCE;
        case (c)
            ASCII_CR:  return OP_CR;
            ASCII_LF:  return OP_LF;
            ASCII_BS:  return OP_BS;
            ASCII_TAB: return OP_TAB;
            ASCII_FF:  return OP_HOME;
            default:   return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_text_console_cursor.sv
// Cursor position, scroll offset and physical row base address of the text console.
// Applies one cursor operation per cycle and flags when a newline will scroll.
module console_cursor
    import uart_text_console_pkg::*;
#(
    parameter int COLS   = 50,
    parameter int ROWS   = 15,
    parameter int ADDR_W = 12,
    parameter int TAB_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  cursor_op_t              op,
    output logic [$clog2(COLS)-1:0] x,
    output logic [$clog2(ROWS)-1:0] y,
    output logic [$clog2(ROWS)-1:0] scroll_row,
    output logic [ADDR_W-1:0]       row_base,
    output logic                    will_scroll
);
    localparam int XW     = $clog2(COLS);
    localparam int YW     = $clog2(ROWS);
    localparam int TAB_SH = $clog2(TAB_W);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(COLS * ROWS - COLS);

    logic [XW:0] tab_x;
    logic        newline;

    always_comb begin
        tab_x       = (({1'b0, x} >> TAB_SH) + (XW + 1)'(1)) << TAB_SH;
        newline     = (op == OP_LF)
                   || ((op == OP_ADVANCE) && (x == XW'(COLS - 1)))
                   || ((op == OP_TAB) && (tab_x >= (XW + 1)'(COLS)));
        will_scroll = newline && (y == YW'(ROWS - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            scroll_row <= '0;
            row_base   <= '0;
        end else begin
            case (op)
                OP_ADVANCE: x <= (x == XW'(COLS - 1)) ? '0 : x + XW'(1);
                OP_CR:      x <= '0;
                OP_BS:      if (x != '0) x <= x - XW'(1);
                OP_TAB:     x <= newline ? '0 : tab_x[XW-1:0];
                OP_HOME: begin
                    x          <= '0;
                    y          <= '0;
                    scroll_row <= '0;
                    row_base   <= '0;
                end
                default: ;
            endcase
            // Moving down a row and scrolling both advance the physical row by one.
            if (newline) begin
                if (will_scroll)
                    scroll_row <= (scroll_row == YW'(ROWS - 1)) ? '0 : scroll_row + YW'(1);
                else
                    y <= y + YW'(1);
                row_base <= (row_base >= LAST_ROW_BASE) ? row_base - LAST_ROW_BASE
                                                        : row_base + ADDR_W'(COLS);
            end
        end
    end

endmodule

// File: rtl/uart_text_console.sv
// Character-terminal front end: turns an accepted byte stream into VRAM write
// strobes, with cursor handling, line wrap, hardware scroll and screen clear.
module uart_text_console
    import uart_text_console_pkg::*;
#(
    parameter int COLS   = 50,
    parameter int ROWS   = 15,
    parameter int ADDR_W = 12,
    parameter int ATTR_W = 8,
    parameter int TAB_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    char_valid,
    input  logic [7:0]              char_data,
    output logic                    char_ready,
    input  logic [ATTR_W-1:0]       attr,
    output logic                    vram_ce,
    output logic [ADDR_W-1:0]       vram_addr,
    output logic [ATTR_W+7:0]       vram_data,
    output logic [$clog2(ROWS)-1:0] scroll_row,
    output logic [$clog2(COLS)-1:0] cursor_x,
    output logic [$clog2(ROWS)-1:0] cursor_y
);
    localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_LAST  = ADDR_W'(COLS * ROWS - 1);

    state_t            state;
    cursor_op_t        op;
    logic              accept;
    logic              will_scroll;
    logic              pend_scroll;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] cell_addr;
    logic [ATTR_W-1:0] attr_q;

    always_comb begin
        accept    = (state == S_IDLE) && char_ready && char_valid;
        op        = accept ? decode_op(char_data) : OP_NONE;
        cell_addr = row_base + ADDR_W'(cursor_x);
    end

    console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TAB_W  (TAB_W)
    ) u_cursor (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .x           (cursor_x),
        .y           (cursor_y),
        .scroll_row  (scroll_row),
        .row_base    (row_base),
        .will_scroll (will_scroll)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_START;
            char_ready  <= 1'b0;
            vram_ce     <= 1'b0;
            vram_addr   <= '0;
            vram_data   <= '0;
            clr_cnt     <= '0;
            attr_q      <= '0;
            pend_scroll <= 1'b0;
        end else begin
            vram_ce <= 1'b0;
            case (state)
                S_START: begin
                    attr_q  <= attr;
                    clr_cnt <= '0;
                    state   <= S_CLEAR_ALL;
                end
                S_IDLE: if (accept) begin
                    attr_q      <= attr;
                    char_ready  <= 1'b0;
                    pend_scroll <= will_scroll;
                    clr_cnt     <= '0;
                    state       <= (char_data == ASCII_FF) ? S_CLEAR_ALL : S_WRITE;
                    // Writes use the pre-update cursor; the cursor moves on this same edge.
                    if (is_printable(char_data)) begin
                        vram_ce   <= 1'b1;
                        vram_addr <= cell_addr;
                        vram_data <= {attr, char_data};
                    end else if ((char_data == ASCII_BS) && (cursor_x != '0)) begin
                        vram_ce   <= 1'b1;
                        vram_addr <= cell_addr - ADDR_W'(1);
                        vram_data <= {attr, ASCII_SP};
                    end
                end
                S_WRITE: begin
                    if (pend_scroll) begin
                        state <= S_CLEAR_LINE;
                    end else begin
                        state      <= S_IDLE;
                        char_ready <= 1'b1;
                    end
                end
                S_CLEAR_LINE: begin
                    vram_ce   <= 1'b1;
                    vram_addr <= row_base + clr_cnt;
                    vram_data <= {attr_q, ASCII_SP};
                    clr_cnt   <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LINE_LAST) begin
                        state      <= S_IDLE;
                        char_ready <= 1'b1;
                    end
                end
                S_CLEAR_ALL: begin
                    vram_ce   <= 1'b1;
                    vram_addr <= clr_cnt;
                    vram_data <= {attr_q, ASCII_SP};
                    clr_cnt   <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ALL_LAST) begin
                        state      <= S_IDLE;
                        char_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_text_console.sv
// Self-checking bench for uart_text_console: directed table, corner-case sequences
// and random bytes checked against a cell-level reference model.
module tb_uart_text_console;

    localparam int COLS  = 50;
    localparam int ROWS  = 15;
    localparam int TAB_W = 4;
    localparam int CELLS = COLS * ROWS;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [7:0]  attr;
    logic        vram_ce;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic [3:0]  scroll_row;
    logic [5:0]  cursor_x;
    logic [3:0]  cursor_y;

    uart_text_console #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (12),
        .ATTR_W (8),
        .TAB_W  (TAB_W)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .attr       (attr),
        .vram_ce    (vram_ce),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .scroll_row (scroll_row),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        int          cyc;
    } strobe_t;

    typedef struct {
        logic [7:0] c;
        int         ex;
        int         ey;
        int         nstr;
        int         eaddr;
        logic [7:0] ech;
    } vec_t;

    strobe_t act_q[$];
    strobe_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mx = 0, my = 0, ms = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vram_ce) begin
            strobe_t s;
            s.addr = vram_addr;
            s.data = vram_data;
            s.cyc  = cyc;
            act_q.push_back(s);
            if (vram_addr > 12'(CELLS - 1)) chk("addr_range", vram_addr, CELLS - 1);
        end
    end

    // ---------------- reference model ----------------
    task automatic push_exp(input int addr, input logic [15:0] d);
        strobe_t s;
        s.addr = 12'(addr);
        s.data = d;
        s.cyc  = -1;
        exp_q.push_back(s);
    endtask

    function automatic int phys(input int x);
        return ((ms + my) % ROWS) * COLS + x;
    endfunction

    task automatic model_newline(input logic [7:0] a);
        if (my < ROWS - 1) begin
            my++;
        end else begin
            ms = (ms + 1) % ROWS;
            for (int i = 0; i < COLS; i++) push_exp(phys(i), {a, 8'h20});
        end
    endtask

    task automatic model_reset(input logic [7:0] a);
        mx = 0; my = 0; ms = 0;
        for (int i = 0; i < CELLS; i++) push_exp(i, {a, 8'h20});
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        int nx;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_exp(phys(mx), {a, c});
            if (mx == COLS - 1) begin mx = 0; model_newline(a); end
            else mx++;
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h0A) begin
            model_newline(a);
        end else if (c == 8'h08) begin
            if (mx > 0) begin mx--; push_exp(phys(mx), {a, 8'h20}); end
        end else if (c == 8'h09) begin
            nx = (mx / TAB_W + 1) * TAB_W;
            if (nx >= COLS) begin mx = 0; model_newline(a); end
            else mx = nx;
        end else if (c == 8'h0C) begin
            model_reset(a);
        end
    endtask

    // ---------------- drivers / checkers ----------------
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("idle_timeout", char_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a, input bit wait_idle);
        int n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (char_ready !== 1'b1) begin
            chk("ready_timeout", char_ready, 1);
            return;
        end
        char_valid = 1'b1; char_data = c; attr = a;
        model_byte(c, a);
        @(posedge clk); #1;
        acc_cyc = cyc;
        char_valid = 1'b0;
        if (wait_idle) wait_ready();
    endtask

    task automatic drain_check(input string name);
        int n;
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        chk({name, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk({name, "_addr"}, act_q[i].addr, exp_q[i].addr);
            chk({name, "_data"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cursor(input string name);
        chk({name, "_x"}, cursor_x, mx);
        chk({name, "_y"}, cursor_y, my);
        chk({name, "_scroll"}, scroll_row, ms);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ce"}, vram_ce, 0);
        chk({name, "_addr"}, vram_addr, 0);
        chk({name, "_data"}, vram_data, 0);
        chk({name, "_ready"}, char_ready, 0);
        chk({name, "_scroll"}, scroll_row, 0);
        chk({name, "_x"}, cursor_x, 0);
        chk({name, "_y"}, cursor_y, 0);
    endtask

    vec_t tbl[18];

    initial begin
        int n;
        int r;
        logic [7:0] c;
        logic [7:0] a;

        tbl[0]  = '{8'h41, 1, 0, 1, 0,  8'h41};
        tbl[1]  = '{8'h42, 2, 0, 1, 1,  8'h42};
        tbl[2]  = '{8'h08, 1, 0, 1, 1,  8'h20};
        tbl[3]  = '{8'h09, 4, 0, 0, 0,  8'h00};
        tbl[4]  = '{8'h0D, 0, 0, 0, 0,  8'h00};
        tbl[5]  = '{8'h08, 0, 0, 0, 0,  8'h00};
        tbl[6]  = '{8'h0A, 0, 1, 0, 0,  8'h00};
        tbl[7]  = '{8'h07, 0, 1, 0, 0,  8'h00};
        tbl[8]  = '{8'h80, 0, 1, 0, 0,  8'h00};
        tbl[9]  = '{8'h61, 1, 1, 1, 50, 8'h61};
        tbl[10] = '{8'h09, 4, 1, 0, 0,  8'h00};
        tbl[11] = '{8'h7E, 5, 1, 1, 54, 8'h7E};
        tbl[12] = '{8'h7F, 5, 1, 0, 0,  8'h00};
        tbl[13] = '{8'h08, 4, 1, 1, 54, 8'h20};
        tbl[14] = '{8'h08, 3, 1, 1, 53, 8'h20};
        tbl[15] = '{8'h08, 2, 1, 1, 52, 8'h20};
        tbl[16] = '{8'h09, 4, 1, 0, 0,  8'h00};
        tbl[17] = '{8'hFF, 4, 1, 0, 0,  8'h00};

        char_valid = 1'b0; char_data = 8'h00; attr = 8'h3C; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset(8'h3C);
        @(negedge clk);
        chk("start_ready", char_ready, 0);
        wait_ready();
        drain_check("boot");
        chk_cursor("boot");

        for (int i = 0; i < 18; i++) begin
            send(tbl[i].c, 8'h5A, 1'b1);
            chk("tbl_x", cursor_x, tbl[i].ex);
            chk("tbl_y", cursor_y, tbl[i].ey);
            chk("tbl_nstrobe", act_q.size(), tbl[i].nstr);
            if (tbl[i].nstr == 1 && act_q.size() == 1) begin
                chk("tbl_addr", act_q[0].addr, tbl[i].eaddr);
                chk("tbl_data", act_q[0].data, {8'h5A, tbl[i].ech});
                chk("tbl_latency", act_q[0].cyc, acc_cyc);
            end
            drain_check("tbl_model");
        end

        send(8'h0C, 8'h11, 1'b1);
        drain_check("ff");
        chk("ff_scroll", scroll_row, 0);
        chk_cursor("ff");

        for (int i = 0; i < 51; i++) begin
            send(8'h78, 8'h22, 1'b1);
            if (i == 50) begin
                chk("wrap_n", act_q.size(), 1);
                if (act_q.size() > 0) chk("wrap_addr", act_q[0].addr, 50);
            end
            drain_check("wrap");
        end
        chk("wrap_x", cursor_x, 1);
        chk("wrap_y", cursor_y, 1);

        send(8'h0D, 8'h22, 1'b1);
        drain_check("cr");
        for (int i = 0; i < 13; i++) begin
            send(8'h0A, 8'h22, 1'b1);
            drain_check("lf");
        end
        chk("bottom_y", cursor_y, 14);
        send(8'h0A, 8'h33, 1'b1);
        chk("scroll_row", scroll_row, 1);
        chk("scroll_y", cursor_y, 14);
        chk("scroll_x", cursor_x, 0);
        chk("scroll_n", act_q.size(), COLS);
        if (act_q.size() == COLS) begin
            chk("scroll_first", act_q[0].addr, 0);
            chk("scroll_last", act_q[COLS-1].addr, COLS - 1);
        end
        drain_check("scroll");
        send(8'h5A, 8'h44, 1'b1);
        if (act_q.size() > 0) begin
            chk("z_addr", act_q[0].addr, 0);
            chk("z_data", act_q[0].data, 16'h445A);
        end
        drain_check("z");

        // Byte offered during a full clear must wait for it to finish.
        send(8'h0C, 8'h55, 1'b0);
        char_valid = 1'b1; char_data = 8'h51; attr = 8'h66;
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("ff_hold_cycles", n, CELLS);
        model_byte(8'h51, 8'h66);
        @(posedge clk); #1;
        char_valid = 1'b0;
        wait_ready();
        drain_check("ff_pending");
        chk_cursor("ff_pending");

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      c = 8'($urandom_range(32, 126));
            else if (r < 65) c = 8'h0D;
            else if (r < 75) c = 8'h0A;
            else if (r < 83) c = 8'h08;
            else if (r < 92) c = 8'h09;
            else if (r < 93) c = 8'h0C;
            else             c = 8'($urandom_range(0, 255));
            a = 8'($urandom);
            send(c, a, 1'b1);
            drain_check("rand");
            chk_cursor("rand");
        end

        // Reset asserted in the middle of a line clear.
        for (int i = 0; i < ROWS; i++) begin
            send(8'h0A, 8'h77, 1'b1);
            drain_check("pre_rst");
        end
        send(8'h0A, 8'h77, 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst_scroll_nz", (scroll_row != 0), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        act_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(8'h77);
        wait_ready();
        drain_check("reclear");
        chk_cursor("reclear");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
